// File: rtl/bchecc_pkg.sv
// Shared GF(2^M) constants, state encoding and constant-multiply helpers for the BCH syndrome unit.
// Helpers work on a 16-bit container, so fields up to GF(2^16) are supported.
package bchecc_pkg;

    localparam int GF_M     = 13;
    localparam logic [GF_M-1:0] GF_POLY = 13'h001B;
    localparam int GF_MW    = 16;
    localparam int GF_MAX_E = 64;
    localparam int GF_MAX_W = 32;

    typedef logic [GF_MW-1:0]    gf_t;
    typedef logic [GF_MAX_W-1:0] gf_data_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic gf_t gf_mul_alpha(input gf_t x, input int m = GF_M, input gf_t poly = gf_t'(GF_POLY));
        gf_t r;
        gf_t mask;
        mask = gf_t'((32'd1 << m) - 32'd1);
        r    = (x << 1) & mask;
        if (x[m-1]) r = r ^ (poly & mask);
        return r;
    endfunction

    function automatic gf_t gf_mul_alpha_pow(input gf_t x, input int e, input int m = GF_M,
                                             input gf_t poly = gf_t'(GF_POLY));
        gf_t r;
        r = x;
        for (int i = 0; i < GF_MAX_E; i++) begin
            if (i < e) r = gf_mul_alpha(r, m, poly);
        end
        return r;
    endfunction

    // One beat of Horner evaluation at alpha^(2k+1), MSB of the beat first.
    function automatic gf_t gf_horner(input gf_t s, input gf_data_t data, input int nbits, input int k,
                                      input int m = GF_M, input gf_t poly = gf_t'(GF_POLY));
        gf_t r;
        r = s;
        for (int i = GF_MAX_W - 1; i >= 0; i--) begin
            if (i < nbits) r = gf_mul_alpha_pow(r, 2 * k + 1, m, poly) ^ gf_t'(data[i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/bchecc_syndm_par_if.sv
// Data-beat stream into the syndrome unit.
interface bchecc_syndm_par_if #(parameter int W = 8);

    logic [W-1:0] din_i;
    logic         din_vld_i;
    logic         din_rdy_o;

    // A beat transfers on every clk edge where din_vld_i & din_rdy_o; the sink never holds a beat, it only ignores it while din_rdy_o is low.
    modport master (output din_i, output din_vld_i, input din_rdy_o);
    modport slave  (input din_i, input din_vld_i, output din_rdy_o);

endinterface

// File: rtl/bchecc_syndm_lane.sv
// One odd syndrome S(2K+1): register plus per-beat Horner update.
module bchecc_syndm_lane
    import bchecc_pkg::*;
#(
    parameter int              M         = GF_M,
    parameter logic [M-1:0]    PRIM_POLY = GF_POLY,
    parameter int              W         = 8,
    parameter int              K         = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         active,
    input  logic [W-1:0] din,
    output logic [M-1:0] synd_d_o,
    output logic [M-1:0] synd_o
);

    logic [M-1:0] synd_q, synd_d;

    always_comb begin
        synd_d = synd_q;
        if (clr || !active) begin
            synd_d = '0;
        end else if (en) begin
            synd_d = M'(gf_horner(gf_t'(synd_q), gf_data_t'(din), W, K, M, gf_t'(PRIM_POLY)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) synd_q <= '0;
        else     synd_q <= synd_d;
    end

    assign synd_d_o = synd_d;
    assign synd_o   = synd_q;

endmodule

// File: rtl/bchecc_syndm_par.sv
// Parametrised odd-syndrome generator for one NAND sector: sequencing FSM, beat counter and zero detect
// around T_MAX Horner lanes.
module bchecc_syndm_par
    import bchecc_pkg::*;
#(
    parameter int           M         = 13,
    parameter logic [M-1:0] PRIM_POLY = 13'h001B,
    parameter int           T_MAX     = 15,
    parameter int           W         = 8,
    parameter int           LEN_W     = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [4:0]           t_sel_i,
    input  logic [LEN_W-1:0]     sec_len_i,
    bchecc_syndm_par_if.slave    din_if,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 zero_o,
    output logic                 synd_vld_o,
    output logic [M*T_MAX-1:0]   synd_o,
    output state_e               state_o
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [4:0]       t_sel_q, t_sel_d;
    logic             done_q, done_d;
    logic             vld_q, vld_d;
    logic             zero_q, zero_d;
    logic             accept, lane_clr, lane_en;
    logic [T_MAX-1:0] lane_act, lane_nz;
    logic [M-1:0]     synd_nxt [T_MAX];

    assign accept = (state_q == ST_ACC) && din_if.din_vld_i;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        t_sel_d  = t_sel_q;
        vld_d    = vld_q;
        lane_clr = 1'b0;
        lane_en  = 1'b0;
        if (abort_i) begin
            state_d  = ST_IDLE;
            vld_d    = 1'b0;
            lane_clr = 1'b1;
        end else if (start_i) begin
            // A beat arriving together with start belongs to the old sector and is dropped.
            lane_clr = 1'b1;
            cnt_d    = sec_len_i;
            t_sel_d  = (t_sel_i == 5'd0 || t_sel_i > 5'(T_MAX)) ? 5'(T_MAX) : t_sel_i;
            if (sec_len_i == '0) begin
                state_d = ST_DONE;
                vld_d   = 1'b1;
            end else begin
                state_d = ST_ACC;
                vld_d   = 1'b0;
            end
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        lane_en = 1'b1;
                        cnt_d   = cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            state_d = ST_DONE;
                            vld_d   = 1'b1;
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: ;
            endcase
        end
        done_d = (state_d == ST_DONE);
        // Inactive lanes are forced to zero, so they never disturb the NOR.
        zero_d = vld_d && !(|lane_nz);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            t_sel_q <= 5'(T_MAX);
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_sel_q <= t_sel_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            zero_q  <= zero_d;
        end
    end

    for (genvar g = 0; g < T_MAX; g++) begin : g_lane
        assign lane_act[g] = (5'(g) < t_sel_q);
        assign lane_nz[g]  = |synd_nxt[g];
        bchecc_syndm_lane #(
            .M(M), .PRIM_POLY(PRIM_POLY), .W(W), .K(g)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clr      (lane_clr),
            .en       (lane_en),
            .active   (lane_act[g]),
            .din      (din_if.din_i),
            .synd_d_o (synd_nxt[g]),
            .synd_o   (synd_o[M*g +: M])
        );
    end

    assign din_if.din_rdy_o = (state_q == ST_ACC);
    assign busy_o           = (state_q == ST_ACC);
    assign done_o           = done_q;
    assign synd_vld_o       = vld_q;
    assign zero_o           = zero_q;
    assign state_o          = state_q;

endmodule

// File: tb/tb_bchecc_syndm_par.sv
// Bench for bchecc_syndm_par: vector table plus hand-written control sequences, checked against
// an alpha-power-table syndrome model through a done-triggered scoreboard.
module tb_bchecc_syndm_par;
    import bchecc_pkg::*;

    localparam int M     = 13;
    localparam int T_MAX = 15;
    localparam int W     = 8;
    localparam int LEN_W = 12;
    localparam int SW    = M * T_MAX;

    logic             clk = 1'b0;
    logic             rst, start_i, abort_i;
    logic [4:0]       t_sel_i;
    logic [LEN_W-1:0] sec_len_i;
    logic             busy_o, done_o, zero_o, synd_vld_o;
    logic [SW-1:0]    synd_o;
    state_e           state_o;

    bchecc_syndm_par_if #(.W(W)) din_if ();

    bchecc_syndm_par #(
        .M(M), .PRIM_POLY(13'h001B), .T_MAX(T_MAX), .W(W), .LEN_W(LEN_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .t_sel_i    (t_sel_i),
        .sec_len_i  (sec_len_i),
        .din_if     (din_if),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .zero_o     (zero_o),
        .synd_vld_o (synd_vld_o),
        .synd_o     (synd_o),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    logic [SW:0]   exp_q[$];
    logic [SW:0]   mon_e;
    logic [7:0]    sec_b[$];
    int            alog[0:8190];

    task automatic check(input string name, input logic [SW:0] act, input logic [SW:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected {zero, synd}: S(2k+1) = sum over set bits j of alpha^((2k+1)j).
    function automatic logic [SW:0] model(input int tsel);
        logic [SW:0]  r;
        logic [M-1:0] s;
        int           ts, n, j;
        bit           nz;
        ts = (tsel == 0 || tsel > T_MAX) ? T_MAX : tsel;
        r  = '0;
        nz = 1'b0;
        n  = sec_b.size();
        for (int k = 0; k < ts; k++) begin
            s = '0;
            for (int b = 0; b < n; b++) begin
                for (int i = 0; i < 8; i++) begin
                    if (sec_b[b][i]) begin
                        j = 8 * (n - 1 - b) + i;
                        s = s ^ M'(alog[((2 * k + 1) * j) % 8191]);
                    end
                end
            end
            r[M*k +: M] = s;
            if (s != '0) nz = 1'b1;
        end
        r[SW] = ~nz;
        return r;
    endfunction

    always @(negedge clk) begin
        if (done_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done_o=1 expected no pending sector");
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_synd", {zero_o, synd_o}, mon_e);
                check("sb_vld", synd_vld_o, 1);
            end
        end
    end

    task automatic do_start(input int len, input int tsel);
        start_i   = 1'b1;
        sec_len_i = LEN_W'(len);
        t_sel_i   = 5'(tsel);
        @(posedge clk); #1;
        start_i   = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b, output int waited);
        bit acc, ok;
        din_if.din_vld_i = 1'b1;
        din_if.din_i     = b;
        ok     = 1'b0;
        waited = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            acc = din_if.din_rdy_o;
            @(posedge clk); #1;
            waited++;
            ok = acc;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL feed_timeout: got no din_rdy_o in 50 cycles expected acceptance");
        end
    endtask

    task automatic send_sector(input int tsel, input bit hold, output int cycles);
        int len, w;
        len    = sec_b.size();
        cycles = 0;
        exp_q.push_back(model(tsel));
        do_start(len, tsel);
        for (int b = 0; b < len; b++) begin
            feed(sec_b[b], w);
            cycles += w;
        end
        if (!hold) din_if.din_vld_i = 1'b0;
        check("done_latency", done_o, 1);
        check("rdy_drop", din_if.din_rdy_o, 0);
    endtask

    typedef struct {
        int           len;
        int           tsel;
        logic [31:0]  data;
        bit           chk1;
        bit           chk3;
        logic [M-1:0] s1;
        logic [M-1:0] s3;
    } vec_t;

    vec_t        vt[8];
    int          cyc, w, done_seen, a;
    logic [SW:0] e_hold;

    initial begin
        a = 1;
        for (int i = 0; i < 8191; i++) begin
            alog[i] = a;
            a = a << 1;
            if ((a & 'h2000) != 0) a = a ^ 'h201B;
        end

        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; t_sel_i = '0; sec_len_i = '0;
        din_if.din_i = '0; din_if.din_vld_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", din_if.din_rdy_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_vld", synd_vld_o, 0);
        check("rst_zero", zero_o, 0);
        check("rst_synd", synd_o, 0);
        check("rst_state", state_o, ST_IDLE);
        rst = 1'b0;
        @(posedge clk); #1;

        vt[0] = '{4, 15, 32'h00000000, 1, 1, 13'h0000, 13'h0000};
        vt[1] = '{1, 15, 32'h01000000, 1, 1, 13'h0001, 13'h0001};
        vt[2] = '{1, 15, 32'h02000000, 1, 1, 13'h0002, 13'h0008};
        vt[3] = '{2, 15, 32'h01000000, 1, 1, 13'h0100, 13'h185A};
        vt[4] = '{2, 1,  32'h5AC30000, 0, 1, 13'h0000, 13'h0000};
        vt[5] = '{3, 0,  32'h80000100, 0, 0, 13'h0000, 13'h0000};
        vt[6] = '{1, 20, 32'hFF000000, 0, 0, 13'h0000, 13'h0000};
        vt[7] = '{0, 15, 32'h00000000, 1, 1, 13'h0000, 13'h0000};

        for (int v = 0; v < 8; v++) begin
            sec_b.delete();
            for (int b = 0; b < vt[v].len; b++) sec_b.push_back(vt[v].data[31-8*b -: 8]);
            send_sector(vt[v].tsel, 1'b0, cyc);
            check("accept_cycles", cyc, vt[v].len);
            if (vt[v].chk1) check("s1_const", synd_o[M-1:0], vt[v].s1);
            if (vt[v].chk3) check("s3_const", synd_o[2*M-1:M], vt[v].s3);
        end

        sec_b.delete();
        for (int b = 0; b < 512; b++) sec_b.push_back(8'($urandom_range(0, 255)));
        send_sector(4, 1'b0, cyc);
        check("tsel4_hi_lanes", synd_o[SW-1:4*M], 0);

        sec_b.delete();
        sec_b.push_back(8'h01);
        e_hold = model(15);
        send_sector(15, 1'b1, cyc);
        for (int i = 0; i < 5; i++) begin
            din_if.din_i = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            check("hold_rdy", din_if.din_rdy_o, 0);
            check("hold_synd", {zero_o, synd_o}, e_hold);
        end
        din_if.din_vld_i = 1'b0;

        do_start(2, 15);
        feed(8'h37, w);
        start_i   = 1'b1;
        sec_len_i = LEN_W'(1);
        t_sel_i   = 5'd15;
        din_if.din_i = 8'hFF;
        @(posedge clk); #1;
        start_i = 1'b0;
        din_if.din_vld_i = 1'b0;
        check("sc_synd", synd_o, 0);
        check("sc_busy", busy_o, 1);
        sec_b.delete();
        sec_b.push_back(8'h00);
        exp_q.push_back(model(15));
        feed(8'h00, w);
        din_if.din_vld_i = 1'b0;
        check("sc_done", done_o, 1);

        do_start(8, 15);
        feed(8'hA5, w);
        feed(8'h3C, w);
        feed(8'h77, w);
        din_if.din_vld_i = 1'b0;
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_vld", synd_vld_o, 0);
        check("abort_synd", synd_o, 0);
        check("abort_state", state_o, ST_IDLE);
        done_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_o) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        @(posedge clk); #1;

        do_start(8, 15);
        feed(8'hC9, w);
        feed(8'h12, w);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mrst_rdy", din_if.din_rdy_o, 0);
        check("mrst_busy", busy_o, 0);
        check("mrst_done", done_o, 0);
        check("mrst_vld", synd_vld_o, 0);
        check("mrst_zero", zero_o, 0);
        check("mrst_synd", synd_o, 0);
        rst = 1'b0;
        din_if.din_vld_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bchecc_syndm_par.md
Name: bchecc_syndm_par

Overview:
- Parametrised successor of the fixed 8-bit, t=15 BCH syndrome unit in the NAND-flash ECC path.
- Computes the odd syndromes S1, S3, …, S(2·T_MAX−1) over GF(2^M) for one sector, accepting W data bits per beat.
- Adds a valid/ready handshake, a runtime correction strength, a sector beat counter, a zero-syndrome flag and abort.
- Sits between the ECC FSM data mux and the BMA stage; its outputs feed the BMA syndrome inputs directly.

Parameters:
- M, 13, Galois field degree; width of each syndrome.
- PRIM_POLY, 13'h001B, primitive polynomial low M bits (x^13+x^4+x^3+x+1).
- T_MAX, 15, maximum correctable bits; number of odd syndromes produced.
- W, 8, data bits per beat (legal: 8, 16, 32).
- LEN_W, 12, width of the sector beat counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  one-cycle pulse; clears syndromes, loads sec_len_i and t_sel_i
- abort_i  in  1  return to IDLE, no done
- t_sel_i  in  5  active strength, 1..T_MAX, sampled on start_i
- sec_len_i  in  LEN_W  beats in sector, including parity, sampled on start_i
- din_i  in  W  data beat; MSB is the highest-order codeword bit
- din_vld_i  in  1  beat valid
- din_rdy_o  out  1  beat accepted when din_vld_i & din_rdy_o
- busy_o  out  1  high in ACC
- done_o  out  1  one-cycle pulse; syndromes final
- zero_o  out  1  all active syndromes zero; valid while synd_vld_o
- synd_vld_o  out  1  syndromes stable; high from done until next start/abort/rst
- synd_o  out  M*T_MAX  S(2k+1) at bits [M*k +: M]

Behaviour:
- Reset (rst high at a clk edge):
  - state IDLE; all syndrome registers 0.
  - din_rdy_o, busy_o, done_o, synd_vld_o = 0; zero_o = 0.
- States: IDLE, ACC, DONE.
  - IDLE --start_i--> ACC. If sec_len_i==0: IDLE --start_i--> DONE directly, syndromes 0.
  - ACC --last beat accepted--> DONE.
  - DONE --next cycle--> IDLE; synd_vld_o stays high.
  - Any state --abort_i--> IDLE; synd_vld_o cleared, syndromes cleared.
- start_i in any state restarts: syndromes cleared, counter reloaded, synd_vld_o cleared. start_i wins over a simultaneous accepted beat; that beat is dropped.
- din_rdy_o = (state==ACC). No input backpressure beyond this; beats offered outside ACC are ignored.
- Per accepted beat, for each active k: S <= Horner(S, din_i), processing bits MSB→LSB within one cycle as S = S·α^(2k+1) XOR bit.
  - Net effect: LSB of the final beat is codeword position 0.
  - GF multiply by a constant uses PRIM_POLY reduction.
- Beat counter loads sec_len_i and decrements per accepted beat. The beat that brings it to 0 is the last; din_rdy_o drops the next cycle.
- Syndromes with index k ≥ t_sel are held at 0 and excluded from zero_o.
- done_o asserts the cycle after the last beat is accepted (1-cycle latency). synd_o is final in the same cycle.
- zero_o is a registered NOR of the active syndromes, valid with synd_vld_o.
- t_sel_i==0 or t_sel_i>T_MAX is clamped to T_MAX.

Decomposition:
- Package bchecc_pkg:
  - GF constants (M, PRIM_POLY).
  - Function gf_mul_alpha_pow(x, e): multiply by α^e.
  - Function gf_horner(s, data, k).
  - State enum.
- Sub-module bchecc_syndm_lane: one syndrome register plus Horner update, parametrised by syndrome index. Generate T_MAX instances.
- Top module: FSM, counter, handshake, zero detect.

Test Plan:
- All-zero data, sec_len=4, t_sel=15:
  - rdy high 4 cycles; done 1 cycle after the 4th beat.
  - All syndromes 0; zero_o=1.
- sec_len=1, din=8'h01: every active S = 0x0001; zero_o=0.
- sec_len=1, din=8'h02: S1 = α = 0x0002, S3 = α^3 = 0x0008, S5 = α^5 = 0x0020.
- sec_len=2, beats 8'h01 then 8'h00: S1 = α^8 = 0x0100. S(2k+1) matches a software model at α^(8(2k+1)).
- t_sel=4, random 512-byte sector:
  - S1..S7 match the model; S9..S29 = 0.
  - zero_o considers only S1..S7.
- Control cases:
  - abort_i mid-sector → IDLE with no done_o.
  - rst mid-sector → all outputs at reset values next cycle.
  - start_i coincident with an accepted beat → that beat is dropped and syndromes are 0.
  - din_vld_i held after the last beat → din_rdy_o=0 and syndromes unchanged.
